// File: rtl/simon_pkg.sv
// Shared constants, FSM state type and z2 lookup for the Simon 128/128 round controller.
// Optional feature macro used by the top: SIMON_CTRL_PERF_EN.
package simon_pkg;

    localparam int ROUNDS_128 = 68;
    localparam int Z_LEN      = 62;
    localparam int ZIDX_W     = 6;
    localparam int BLK_W      = 128;

    // Bit 0 of the sequence is the leftmost character, i.e. vector bit Z_LEN-1.
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAPT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic z2_bit(input logic [ZIDX_W-1:0] idx);
        return Z2[ZIDX_W'(Z_LEN - 1) - idx];
    endfunction

endpackage

// File: rtl/simon_zseq.sv
// z2 sequence position tracker: clears on block load, advances one position per round step.
module simon_zseq
    import simon_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    output logic [ZIDX_W-1:0] o_zidx,
    output logic              o_zbit
);

    logic [ZIDX_W-1:0] r_zidx;
    logic [ZIDX_W-1:0] w_zidx_nxt;

    // Successor index with wrap from the last sequence position back to 0, no stall.
    always_comb begin
        w_zidx_nxt = r_zidx + ZIDX_W'(1);
        if (r_zidx == ZIDX_W'(Z_LEN - 1)) begin
            w_zidx_nxt = {ZIDX_W{1'b0}};
        end else begin
            w_zidx_nxt = r_zidx + ZIDX_W'(1);
        end
    end

    // Index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zidx <= {ZIDX_W{1'b0}};
        end else if (i_load) begin
            r_zidx <= {ZIDX_W{1'b0}};
        end else if (i_step) begin
            r_zidx <= w_zidx_nxt;
        end
    end

    assign o_zidx = r_zidx;
    assign o_zbit = z2_bit(r_zidx);

endmodule

// File: rtl/simon_ctrl.sv
// Simon 128/128 round controller: request/response handshakes, round sequencing, ciphertext capture.
// Define SIMON_CTRL_PERF_EN to add the perf_blocks_o completed-block counter.
module simon_ctrl
    import simon_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_128,
    parameter int RND_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [BLK_W-1:0] pt_i,
    input  logic [BLK_W-1:0] k0_i,
    output logic             dp_load_o,
    output logic [BLK_W-1:0] dp_pt_o,
    output logic [BLK_W-1:0] dp_key_o,
    output logic             dp_step_o,
    output logic [RND_W-1:0] dp_round_o,
    output logic             dp_zbit_o,
    input  logic [BLK_W-1:0] dp_state_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [BLK_W-1:0] ct_o,
    input  logic             abort_i,
    output logic             busy_o
`ifdef SIMON_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_blocks_o
`endif
);

    state_e            r_state;
    state_e            w_next;
    logic              r_armed;
    logic [RND_W-1:0]  r_round;
    logic [BLK_W-1:0]  r_ct;
    logic              w_accept;
    logic              w_last;
    logic              w_resp_hs;
    logic [ZIDX_W-1:0] w_zidx;

    assign req_ready_o  = (r_state == ST_IDLE) && r_armed;
    assign w_accept     = req_valid_i && req_ready_o;
    assign w_last       = (r_round == RND_W'(ROUNDS - 1));
    assign w_resp_hs    = (r_state == ST_DONE) && resp_ready_i;

    assign dp_load_o    = w_accept;
    assign dp_pt_o      = pt_i;
    assign dp_key_o     = k0_i;
    assign dp_step_o    = (r_state == ST_RUN);
    assign dp_round_o   = r_round;
    assign resp_valid_o = (r_state == ST_DONE);
    assign busy_o       = (r_state != ST_IDLE);
    assign ct_o         = r_ct;

    // Keeps the request side closed while reset is held; opens on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort only matters while rounds are running or being captured.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_RUN;
                else          w_next = ST_IDLE;
            end
            ST_RUN: begin
                if (abort_i)     w_next = ST_IDLE;
                else if (w_last) w_next = ST_CAPT;
                else             w_next = ST_RUN;
            end
            ST_CAPT: begin
                if (abort_i) w_next = ST_IDLE;
                else         w_next = ST_DONE;
            end
            ST_DONE: begin
                if (resp_ready_i) w_next = ST_IDLE;
                else              w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Round index; holds at the last round rather than running past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_round <= {RND_W{1'b0}};
        end else if (w_accept) begin
            r_round <= {RND_W{1'b0}};
        end else if ((r_state == ST_RUN) && !w_last) begin
            r_round <= r_round + RND_W'(1);
        end
    end

    // Ciphertext capture; an abort during capture leaves the previous ciphertext in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ct <= {BLK_W{1'b0}};
        end else if ((r_state == ST_CAPT) && !abort_i) begin
            r_ct <= dp_state_i;
        end
    end

    simon_zseq u_zseq (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (dp_load_o),
        .i_step (dp_step_o),
        .o_zidx (w_zidx),
        .o_zbit (dp_zbit_o)
    );

`ifdef SIMON_CTRL_PERF_EN
    logic [31:0] r_perf;

    // Completed-response counter; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf <= 32'd0;
        end else if (w_resp_hs) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_blocks_o = r_perf;
`else
    logic w_unused;
    assign w_unused = w_resp_hs ^ (^w_zidx);
`endif

endmodule

// File: tb/tb_simon_ctrl.sv
// Self-checking bench for simon_ctrl with a behavioural Simon 128/128 round datapath bound to it.
module tb_simon_ctrl;

    localparam int ROUNDS = 68;
    localparam int RND_W  = 7;
    localparam int LAT    = 70;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid_i = 1'b0;
    logic           req_ready_o;
    logic [127:0]   pt_i = '0;
    logic [127:0]   k0_i = '0;
    logic           dp_load_o;
    logic [127:0]   dp_pt_o;
    logic [127:0]   dp_key_o;
    logic           dp_step_o;
    logic [RND_W-1:0] dp_round_o;
    logic           dp_zbit_o;
    logic [127:0]   dp_state_i;
    logic           resp_valid_o;
    logic           resp_ready_i = 1'b0;
    logic [127:0]   ct_o;
    logic           abort_i = 1'b0;
    logic           busy_o;
`ifdef SIMON_CTRL_PERF_EN
    logic [31:0]    perf_blocks_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    string z2s = "10101111011100000011010010011000101000010001111110010110110011";

    always #5 clk = ~clk;

    simon_ctrl #(.ROUNDS(ROUNDS), .RND_W(RND_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .pt_i         (pt_i),
        .k0_i         (k0_i),
        .dp_load_o    (dp_load_o),
        .dp_pt_o      (dp_pt_o),
        .dp_key_o     (dp_key_o),
        .dp_step_o    (dp_step_o),
        .dp_round_o   (dp_round_o),
        .dp_zbit_o    (dp_zbit_o),
        .dp_state_i   (dp_state_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .ct_o         (ct_o),
        .abort_i      (abort_i),
        .busy_o       (busy_o)
`ifdef SIMON_CTRL_PERF_EN
        ,
        .perf_blocks_o(perf_blocks_o)
`endif
    );

    function automatic logic [63:0] rol(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic zref(input int r);
        return (z2s[r % 62] == "1");
    endfunction

    // Whole-block Simon 128/128 encryption: full key expansion first, then all rounds.
    function automatic logic [127:0] simon_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [63:0] k [0:ROUNDS-1];
        logic [63:0] x, y, t;
        k[0] = key[63:0];
        k[1] = key[127:64];
        for (int i = 0; i < ROUNDS - 2; i++)
            k[i+2] = ~k[i] ^ ror(k[i+1], 3) ^ ror(k[i+1], 4) ^ {63'd0, zref(i)} ^ 64'd3;
        x = pt[127:64];
        y = pt[63:0];
        for (int i = 0; i < ROUNDS; i++) begin
            t = x;
            x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    // Round datapath driven by the controller's strobes, consuming the key on the fly.
    logic [63:0] dx, dy, dka, dkb;
    always @(posedge clk) begin
        if (dp_load_o) begin
            dx  <= dp_pt_o[127:64];
            dy  <= dp_pt_o[63:0];
            dka <= dp_key_o[63:0];
            dkb <= dp_key_o[127:64];
        end else if (dp_step_o) begin
            dx  <= dy ^ ((rol(dx, 1) & rol(dx, 8)) ^ rol(dx, 2)) ^ dka;
            dy  <= dx;
            dka <= dkb;
            dkb <= ~dka ^ ror(dkb, 3) ^ ror(dkb, 4) ^ {63'd0, dp_zbit_o} ^ 64'd3;
        end
    end
    assign dp_state_i = {dx, dy};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"}, req_ready_o, 0);
        chk({tag, " resp_valid"}, resp_valid_o, 0);
        chk({tag, " busy"}, busy_o, 0);
        chk({tag, " dp_step"}, dp_step_o, 0);
        chk({tag, " ct"}, ct_o, 0);
`ifdef SIMON_CTRL_PERF_EN
        chk({tag, " perf"}, perf_blocks_o, 0);
`endif
    endtask

    // Present one request at a negedge and let it be accepted on the following posedge.
    task automatic accept(input logic [127:0] pt, input logic [127:0] key);
        @(negedge clk);
        chk("ready before accept", req_ready_o, 1);
        req_valid_i = 1'b1;
        pt_i = pt;
        k0_i = key;
        #1;
        chk("dp_load on accept", dp_load_o, 1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    // Full block: latency, round/z trace, backpressure with ignored abort, handshake.
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp_ct, input int bp);
        int lat = 0;
        int terr = 0;
        logic [127:0] held;
        accept(pt, key);
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            if (resp_valid_o === 1'b1) begin
                lat = i;
                break;
            end
            if (req_ready_o !== 1'b0 || busy_o !== 1'b1) terr++;
            if (i <= ROUNDS) begin
                if (dp_step_o !== 1'b1 || dp_round_o !== RND_W'(i - 1) || dp_zbit_o !== zref(i - 1)) terr++;
            end else if (dp_step_o !== 1'b0) begin
                terr++;
            end
        end
        chk({tag, " latency"}, lat, LAT);
        chk({tag, " round/z trace errs"}, terr, 0);
        chk({tag, " ct"}, ct_o, exp_ct);
        held = ct_o;
        terr = 0;
        for (int i = 0; i < bp; i++) begin
            abort_i = 1'b1;
            @(negedge clk);
            if (ct_o !== held || req_ready_o !== 1'b0 || resp_valid_o !== 1'b1 || busy_o !== 1'b1) terr++;
        end
        abort_i = 1'b0;
        chk({tag, " backpressure errs"}, terr, 0);
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_i = 1'b0;
        hs_cnt++;
        @(negedge clk);
        chk({tag, " idle after hs"}, {req_ready_o, resp_valid_o, busy_o}, 3'b100);
        chk({tag, " ct after hs"}, ct_o, exp_ct);
`ifdef SIMON_CTRL_PERF_EN
        chk({tag, " perf"}, perf_blocks_o, hs_cnt);
`endif
    endtask

    // Abort in flight at cycle c after accept (round c-1 while running).
    task automatic abort_block(input string tag, input int c, input logic [127:0] prev_ct);
        int terr = 0;
        accept({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        for (int i = 1; i < c; i++) @(negedge clk);
        @(negedge clk);
        chk({tag, " busy before abort"}, busy_o, 1);
        if (c <= ROUNDS) chk({tag, " round at abort"}, dp_round_o, c - 1);
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        @(negedge clk);
        chk({tag, " idle after abort"}, {req_ready_o, resp_valid_o, busy_o, dp_step_o}, 4'b1000);
        chk({tag, " ct unchanged"}, ct_o, prev_ct);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) terr++;
        end
        chk({tag, " no response errs"}, terr, 0);
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        int           bp;
        logic [127:0] exp_ct;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [127:0] last_ct;
        int terr;

        tbl[0].pt     = 128'h63736564207372656c6c657661727420;
        tbl[0].key    = 128'h0f0e0d0c0b0a09080706050403020100;
        tbl[0].bp     = 20;
        tbl[0].exp_ct = 128'h49681b1e1e54fe3f65aa832af84e0bbc;
        for (int i = 1; i < 6; i++) begin
            tbl[i].pt     = {$urandom, $urandom, $urandom, $urandom};
            tbl[i].key    = {$urandom, $urandom, $urandom, $urandom};
            tbl[i].bp     = int'($urandom_range(0, 5));
            tbl[i].exp_ct = simon_ref(tbl[i].pt, tbl[i].key);
        end

        repeat (3) @(negedge clk);
        chk_reset_vals("reset hold");
        rst_n = 1'b1;
        #1;
        chk("ready before first edge", req_ready_o, 0);
        @(negedge clk);
        chk("ready after release", req_ready_o, 1);

        for (int i = 0; i < 6; i++) begin
            run_block($sformatf("vec%0d", i), tbl[i].pt, tbl[i].key, tbl[i].exp_ct, tbl[i].bp);
        end
        last_ct = tbl[5].exp_ct;

        abort_block("abort run30", 31, last_ct);
        run_block("after abort", tbl[0].pt, tbl[0].key, tbl[0].exp_ct, 1);
        abort_block("abort capt", 69, tbl[0].exp_ct);
        run_block("after capt abort", tbl[2].pt, tbl[2].key, tbl[2].exp_ct, 0);

        accept(tbl[3].pt, tbl[3].key);
        repeat (51) @(negedge clk);
        chk("round before reset", dp_round_o, 50);
        rst_n = 1'b0;
        hs_cnt = 0;
        #1;
        chk_reset_vals("mid-block reset");
        @(negedge clk);
        chk_reset_vals("mid-block reset held");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after mid reset", req_ready_o, 1);
        terr = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) terr++;
        end
        chk("no response after reset errs", terr, 0);

        run_block("post reset", tbl[4].pt, tbl[4].key, tbl[4].exp_ct, 2);
`ifdef SIMON_CTRL_PERF_EN
        chk("perf final", perf_blocks_o, hs_cnt);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/simon_ctrl.md
SIMON_CTRL -- requirements
Module: simon_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 68: round steps per block (Simon 128/128).
REQ-002 SHALL have parameter RND_W, default 7: width of the round index, at least clog2(ROUNDS).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid_i, input, 1: block request valid.
REQ-006 SHALL have port req_ready_o, output, 1: controller accepts a request.
REQ-007 SHALL have port pt_i, input, 128: plaintext, sampled on the accept cycle.
REQ-008 SHALL have port k0_i, input, 128: key, sampled on the accept cycle.
REQ-009 SHALL have port dp_load_o, output, 1: load pt and key into the round datapath.
REQ-010 SHALL have port dp_pt_o / dp_key_o, output, 128 each: pass-through of pt_i / k0_i.
REQ-011 SHALL have port dp_step_o, output, 1: advance the datapath by one round.
REQ-012 SHALL have port dp_round_o, output, RND_W: index of the current round.
REQ-013 SHALL have port dp_zbit_o, output, 1: key-schedule z2 constant bit for the current round.
REQ-014 SHALL have port dp_state_i, input, 128: datapath state (ciphertext after the final round).
REQ-015 SHALL have port resp_valid_o, output, 1: ciphertext valid.
REQ-016 SHALL have port resp_ready_i, input, 1: consumer accepts the ciphertext.
REQ-017 SHALL have port ct_o, output, 128: registered ciphertext.
REQ-018 SHALL have port abort_i, input, 1: cancel the block in flight.
REQ-019 SHALL have port busy_o, output, 1: high whenever the state is not IDLE.

Function
REQ-020 SHALL implement the FSM IDLE -> RUN -> CAPT -> DONE -> IDLE.
REQ-021 req_ready_o SHALL be 1 only in IDLE; accept occurs when req_valid_i && req_ready_o.
REQ-022 On accept, dp_load_o SHALL be 1 in that same cycle, combinationally; the state then moves to RUN and the round counter is cleared to 0.
REQ-023 In RUN, dp_step_o SHALL be 1 every cycle and dp_round_o SHALL count 0..ROUNDS-1, one per cycle.
REQ-024 After the cycle with dp_round_o == ROUNDS-1, the state SHALL go to CAPT; in CAPT, ct_o is loaded from dp_state_i.
REQ-025 In DONE, resp_valid_o SHALL be 1 and ct_o SHALL be held stable until resp_ready_i is 1; then the state returns to IDLE.
REQ-026 Latency: accept in cycle T gives RUN in T+1..T+68, CAPT in T+69, resp_valid_o first high in T+70.
REQ-027 The earliest next accept SHALL be the cycle after the response handshake; the controller never overlaps blocks.
REQ-028 dp_zbit_o SHALL equal Z2[dp_round_o mod 62], where Z2 = 10101111011100000011010010011000101000010001111110010110110011 and bit 0 is the leftmost.
REQ-029 The z index SHALL wrap from 61 to 0 without a stall.
REQ-030 abort_i in RUN or CAPT SHALL return the state to IDLE on the next edge, with no response, and leave ct_o unchanged.
REQ-031 abort_i SHALL be ignored in IDLE and in DONE.
REQ-032 The dp_* strobes SHALL be 0 in every state other than those named above.

Reset
REQ-033 While rst_n is 0: state = IDLE; round counter, z index and ct_o = 0.
REQ-034 While rst_n is 0: resp_valid_o, dp_step_o and busy_o = 0.
REQ-035 req_ready_o SHALL be 1 from the first edge after rst_n deasserts.
REQ-036 Reset mid-block SHALL discard the block; no partial response is produced.

Configuration
REQ-037 With SIMON_CTRL_PERF_EN defined: output perf_blocks_o [31:0], reset 0, increments on each response handshake, wraps 0xFFFFFFFF -> 0; aborted blocks are not counted.
REQ-038 Without SIMON_CTRL_PERF_EN: neither the port nor the counter exists.

Structure
REQ-039 Package simon_pkg SHALL hold: ROUNDS_128 = 68, Z2 (62-bit constant), Z_LEN = 62, BLK_W = 128, the FSM state enum.
REQ-040 Sub-module simon_zseq SHALL generate the z index/bit: clear on load, advance on step.

Verification
REQ-041 Reset: hold rst_n = 0 -> req_ready_o = 0, resp_valid_o = 0, ct_o = 0; release -> req_ready_o = 1.
REQ-042 Encrypt with the reference datapath bound: pt 63736564207372656c6c657661727420, key 0f0e0d0c0b0a09080706050403020100 -> ct_o 49681b1e1e54fe3f65aa832af84e0bbc, resp_valid_o at T+70.
REQ-043 Trace dp_zbit_o for rounds 0..67 -> matches Z2 bits 0..61, then bits 0..5.
REQ-044 Backpressure: resp_ready_i held 0 for 20 cycles -> ct_o stable, req_ready_o = 0 throughout; then one-cycle handshake -> IDLE.
REQ-045 abort_i at RUN round 30 -> IDLE next cycle, resp_valid_o never asserts; the following block completes normally.
REQ-046 rst_n pulsed low at round 50 -> all outputs at reset values, no response; perf_blocks_o (SIMON_CTRL_PERF_EN) equals the count of completed handshakes.
